// File: rtl/boot_rom_pkg.sv
// Shared types and helpers for the boot ROM arbiter and its round-robin core.
// Imported by the arbiter top and by the reusable round-robin sub-module.
package boot_rom_pkg;

    localparam int BOOT_ROM_RDATA_LAT   = 1;
    localparam int BOOT_ROM_MAX_MASTERS = 16;
    localparam int BOOT_ROM_IDX_W       = $clog2(BOOT_ROM_MAX_MASTERS);

    typedef struct packed {
        logic                      valid;
        logic [BOOT_ROM_IDX_W-1:0] idx;
        logic                      err;
    } boot_rom_resp_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/boot_rom_rr_arbiter.sv
// Round-robin requester selection with a rotating priority pointer.
// Also used by the debug-side ROM mirror.
module boot_rom_rr_arbiter
    import boot_rom_pkg::*;
#(
    parameter int NB_MASTERS = 2,
    parameter int IDX_W      = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NB_MASTERS-1:0] req_i,
    output logic [NB_MASTERS-1:0] gnt_o,
    output logic [IDX_W-1:0]      winner_o,
    output logic                  valid_o
);

    logic [IDX_W-1:0] rr_d;
    logic [IDX_W-1:0] rr_q;
    int               cand;

    always_comb begin
        gnt_o    = '0;
        winner_o = '0;
        valid_o  = 1'b0;
        cand     = 0;
        for (int k = 0; k < NB_MASTERS; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NB_MASTERS) begin
                cand = cand - NB_MASTERS;
            end
            if (!valid_o && req_i[cand]) begin
                valid_o  = 1'b1;
                winner_o = IDX_W'(cand);
            end
        end
        // Requests seen while in reset are left for the first cycle after it.
        if (rst_i) begin
            valid_o = 1'b0;
        end
        if (valid_o) begin
            gnt_o[winner_o] = 1'b1;
        end
        rr_d = rr_q;
        if (valid_o) begin
            rr_d = IDX_W'(rr_next(int'(winner_o), NB_MASTERS));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Shares the single-port boot ROM between several req/gnt/r_valid masters.
// Reads hit the ROM; writes are granted but answered with an error.
module boot_rom_arbiter
    import boot_rom_pkg::*;
#(
    parameter int NB_MASTERS     = 2,
    parameter int ROM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NB_MASTERS-1:0]                req_i,
    input  logic [NB_MASTERS-1:0][31:0]          add_i,
    input  logic [NB_MASTERS-1:0]                wen_i,
    output logic [NB_MASTERS-1:0]                gnt_o,
    output logic [NB_MASTERS-1:0]                r_valid_o,
    output logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] r_rdata_o,
    output logic [NB_MASTERS-1:0]                r_opc_o,
    output logic                                 rom_csn_o,
    output logic [ROM_ADDR_WIDTH-3:0]            rom_add_o,
    input  logic [DATA_WIDTH-1:0]                rom_rdata_i
);

    localparam int IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
    localparam int LAT   = BOOT_ROM_RDATA_LAT;

    logic [NB_MASTERS-1:0]   gnt;
    logic [IDX_W-1:0]        winner;
    logic                    any_gnt;
    logic                    rom_rd;
    logic [ROM_ADDR_WIDTH-3:0] rom_add_d;
    logic [ROM_ADDR_WIDTH-3:0] rom_add_q;
    boot_rom_resp_t [LAT-1:0] resp_d;
    boot_rom_resp_t [LAT-1:0] resp_q;
    boot_rom_resp_t          resp_out;
    logic [NB_MASTERS-1:0]   sel;
    logic                    unused_add;

    assign unused_add = ^add_i;

    boot_rom_rr_arbiter #(
        .NB_MASTERS (NB_MASTERS),
        .IDX_W      (IDX_W)
    ) u_rr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .gnt_o    (gnt),
        .winner_o (winner),
        .valid_o  (any_gnt)
    );

    always_comb begin
        rom_rd    = any_gnt && wen_i[winner];
        rom_add_d = rom_add_q;
        if (rom_rd) begin
            rom_add_d = add_i[winner][ROM_ADDR_WIDTH-1:2];
        end
        resp_d[0].valid = any_gnt;
        resp_d[0].idx   = BOOT_ROM_IDX_W'(winner);
        resp_d[0].err   = ~wen_i[winner];
        for (int k = 1; k < LAT; k++) begin
            resp_d[k] = resp_q[k-1];
        end
    end

    assign gnt_o     = gnt;
    assign rom_csn_o = ~rom_rd;
    assign rom_add_o = rom_add_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

    // Address is a pure datapath hold; the ROM ignores it while deselected.
    always_ff @(posedge clk_i) begin
        rom_add_q <= rom_add_d;
    end

    always_comb begin
        resp_out  = resp_q[LAT-1];
        sel       = '0;
        r_valid_o = '0;
        r_opc_o   = '0;
        r_rdata_o = '0;
        for (int i = 0; i < NB_MASTERS; i++) begin
            sel[i] = resp_out.valid && !rst_i &&
                     (resp_out.idx == BOOT_ROM_IDX_W'(i));
            r_valid_o[i] = sel[i];
            r_opc_o[i]   = sel[i] && resp_out.err;
            if (sel[i] && !resp_out.err) begin
                r_rdata_o[i] = rom_rdata_i;
            end
        end
    end

    a_gnt_onehot : assert property (
        @(posedge clk_i) $onehot0(gnt_o)
    );

    a_csn_read : assert property (
        @(posedge clk_i) !rom_csn_o |-> |(gnt_o & wen_i)
    );

    a_rvalid_onehot : assert property (
        @(posedge clk_i) $onehot0(r_valid_o)
    );

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Directed and random stimulus for boot_rom_arbiter with a response scoreboard.
// A behavioural ROM returns data one cycle after chip select.
module tb_boot_rom_arbiter;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [1:0][31:0] add;
    logic [1:0]       wen;
    logic [1:0]       gnt;
    logic [1:0]       r_valid;
    logic [1:0][31:0] r_rdata;
    logic [1:0]       r_opc;
    logic             rom_csn;
    logic [10:0]      rom_add;
    logic [31:0]      rom_rdata;

    logic [31:0] rom_mem [2048];
    exp_t        sb [$];
    int          model_rr;
    logic [10:0] last_add;
    bit          last_add_vld;
    int          checks;
    int          errors;

    boot_rom_arbiter #(
        .NB_MASTERS     (2),
        .ROM_ADDR_WIDTH (13),
        .DATA_WIDTH     (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .add_i       (add),
        .wen_i       (wen),
        .gnt_o       (gnt),
        .r_valid_o   (r_valid),
        .r_rdata_o   (r_rdata),
        .r_opc_o     (r_opc),
        .rom_csn_o   (rom_csn),
        .rom_add_o   (rom_add),
        .rom_rdata_i (rom_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rom_csn) begin
            rom_rdata <= rom_mem[rom_add];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic [1:0] rq,
                         input logic [1:0] we, input logic [31:0] a0,
                         input logic [31:0] a1);
        exp_t             e;
        logic [1:0]       eg;
        logic [1:0]       ev;
        logic [1:0]       eo;
        logic [1:0][31:0] ed;
        logic [31:0]      wa;
        logic [10:0]      wadd;
        int               w;
        int               c;
        @(posedge clk);
        #1;
        rst    = r;
        req    = rq;
        wen    = we;
        add[0] = a0;
        add[1] = a1;
        #3;
        ev = '0;
        eo = '0;
        ed = '0;
        if (r) begin
            sb.delete();
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            ev[e.idx] = 1'b1;
            eo[e.idx] = e.err;
            ed[e.idx] = e.data;
        end
        check("r_valid", 64'(r_valid), 64'(ev));
        check("r_opc", 64'(r_opc), 64'(eo));
        check("r_rdata", r_rdata, ed);
        eg = '0;
        w  = -1;
        if (!r) begin
            for (int k = 0; k < 2; k++) begin
                c = (model_rr + k) % 2;
                if (w < 0 && rq[c]) w = c;
            end
        end
        if (w >= 0) begin
            eg[w]  = 1'b1;
            wa     = (w == 0) ? a0 : a1;
            wadd   = wa[12:2];
            e.idx  = w;
            e.err  = ~we[w];
            e.data = we[w] ? rom_mem[wadd] : 32'h0;
            sb.push_back(e);
            model_rr = (w + 1) % 2;
            if (we[w]) begin
                last_add     = wadd;
                last_add_vld = 1'b1;
            end
        end
        if (r) model_rr = 0;
        check("gnt", 64'(gnt), 64'(eg));
        check("rom_csn", 64'(rom_csn), 64'(!(w >= 0 && we[w])));
        if (last_add_vld) check("rom_add", 64'(rom_add), 64'(last_add));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        model_rr     = 0;
        last_add     = '0;
        last_add_vld = 1'b0;
        rst          = 1'b1;
        req          = '0;
        wen          = '1;
        add          = '0;
        rom_rdata    = '0;
        for (int i = 0; i < 2048; i++) begin
            rom_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0103);
        end
        rom_mem[2] = 32'hDEAD_BEEF;

        // reset with both requesting
        cycle(1, 2'b11, 2'b11, 32'h0, 32'h4);
        cycle(1, 2'b11, 2'b11, 32'h0, 32'h4);
        cycle(1, 2'b11, 2'b11, 32'h0, 32'h4);
        // first grant after reset goes to master 0 (word 2)
        cycle(0, 2'b11, 2'b11, 32'h0000_0008, 32'h0000_0020);
        cycle(0, 2'b00, 2'b11, 32'h0, 32'h0);
        // single read from master 0
        cycle(0, 2'b01, 2'b11, 32'h0000_0008, 32'h0);
        cycle(0, 2'b00, 2'b11, 32'h0, 32'h0);
        // contention
        cycle(0, 2'b11, 2'b11, 32'h0000_0040, 32'h0000_0100);
        cycle(0, 2'b11, 2'b11, 32'h0000_0044, 32'h0000_0104);
        cycle(0, 2'b11, 2'b11, 32'h0000_0048, 32'h0000_0108);
        cycle(0, 2'b11, 2'b11, 32'h0000_004C, 32'h0000_010C);
        cycle(0, 2'b00, 2'b11, 32'h0, 32'h0);
        // write from master 1, then rr check with both requesting
        cycle(0, 2'b10, 2'b01, 32'h0, 32'h0000_0010);
        cycle(0, 2'b11, 2'b11, 32'h0000_0200, 32'h0000_0300);
        cycle(0, 2'b11, 2'b10, 32'h0000_0204, 32'h0000_0304);
        cycle(0, 2'b00, 2'b11, 32'h0, 32'h0);
        // reset while a response is pending, request held through reset
        cycle(0, 2'b01, 2'b11, 32'h0000_0030, 32'h0);
        cycle(1, 2'b01, 2'b11, 32'h0000_0030, 32'h0);
        cycle(0, 2'b00, 2'b11, 32'h0, 32'h0);
        cycle(0, 2'b10, 2'b11, 32'h0, 32'h0000_0034);
        cycle(0, 2'b01, 2'b11, 32'h0000_0038, 32'h0);
        cycle(0, 2'b00, 2'b11, 32'h0, 32'h0);
        // upper and lower address bits ignored
        cycle(0, 2'b01, 2'b11, 32'hFFFF_E004, 32'h0);
        cycle(0, 2'b10, 2'b11, 32'h0, 32'h1234_7FFF);
        cycle(0, 2'b00, 2'b11, 32'h0, 32'h0);
        // random traffic
        for (int n = 0; n < 40; n++) begin
            cycle((n % 17) == 16,
                  2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)),
                  $urandom, $urandom);
        end
        cycle(0, 2'b00, 2'b11, 32'h0, 32'h0);
        cycle(0, 2'b00, 2'b11, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
